// File: rtl/updown_button_ctrl.sv
// -----------------------------------------------------------------------------
// updown_button_ctrl
//   Front-end for a 4-bit up/down counter. Two raw push-buttons are
//   synchronised and debounced. A press/hold/release FSM then arbitrates
//   between them and produces:
//     - a direction level (DNUP): 0 = count up, 1 = count down
//     - a single-cycle count pulse (STEP)
//
//   Optional feature macro: AUTO_REPEAT_EN
//     When it is defined, a held button repeats STEP. The first repeat comes
//     HOLD_CYCLES after the first STEP, then one every REPEAT_CYCLES.
//     When it is undefined, each accepted press gives exactly one STEP.
//
// Ports
//   CLK     in   system clock, rising edge
//   ResetN  in   asynchronous active-low reset
//   BTN_UP  in   raw up button, asynchronous and bouncy, 1 = pressed
//   BTN_DN  in   raw down button, asynchronous and bouncy, 1 = pressed
//   DNUP    out  registered direction, 0 = up, 1 = down
//   STEP    out  registered one-cycle count pulse
//
// Latency
//   From the first edge that samples a stable press to STEP high is
//   DEBOUNCE_CYCLES+3 cycles:
//     - 2 synchroniser stages
//     - DEBOUNCE_CYCLES samples to accept the new level
//     - 1 FSM decision cycle (DNUP updates here)
//     - 1 cycle for the STEP register
// -----------------------------------------------------------------------------
module updown_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic CLK,
    input  logic ResetN,
    input  logic BTN_UP,
    input  logic BTN_DN,
    output logic DNUP,
    output logic STEP
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] LOCK = 2'd2;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0] state_q, state_d;
    logic       dnup_q, dnup_d;
    logic       fire_q, fire_d;
    logic       step_q;

    // ---------------------------------------------------------------------
    // Synchroniser and debounce
    // ---------------------------------------------------------------------
    always_comb begin
        deb_d    = deb_q;
        cnt_d[0] = '0;
        cnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                // Accept the new level on the DEBOUNCE_CYCLES-th
                // consecutive differing sample. Any match in between
                // clears the counter, because the default above is zero.
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= {BTN_DN, BTN_UP};
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // ---------------------------------------------------------------------
    // Arbitration FSM
    // ---------------------------------------------------------------------
    // While in HELD, the owning button is identified by DNUP itself.
    logic own_deb, other_deb;
    assign own_deb   = dnup_q ? deb_q[1] : deb_q[0];
    assign other_deb = dnup_q ? deb_q[0] : deb_q[1];

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             rep_q, rep_d;
    logic [CNT_W-1:0] hold_last;
    assign hold_last = rep_q ? CNT_W'(REPEAT_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1);
`else
    // The repeat parameters only matter for the auto-repeat build.
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

    always_comb begin
        state_d = state_q;
        dnup_d  = dnup_q;
        fire_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
        // The hold counter is cleared whenever the FSM is not staying in HELD.
        hold_d  = '0;
        rep_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // In IDLE both levels were low on entry, so a high level here
                // is a fresh rising edge.
                case (deb_q)
                    2'b01: begin
                        dnup_d  = 1'b0;
                        fire_d  = 1'b1;
                        state_d = HELD;
                    end
                    2'b10: begin
                        dnup_d  = 1'b1;
                        fire_d  = 1'b1;
                        state_d = HELD;
                    end
                    2'b11:   state_d = LOCK;
                    default: state_d = IDLE;
                endcase
            end
            HELD: begin
                if (other_deb) begin
                    state_d = LOCK;
                end else if (!own_deb) begin
                    state_d = IDLE;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (hold_q == hold_last) begin
                        fire_d = 1'b1;
                        rep_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                        rep_d  = rep_q;
                    end
`endif
                end
            end
            LOCK: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM and output registers
    // ---------------------------------------------------------------------
    // The FSM updates DNUP and sets fire_q on the same edge. STEP follows
    // fire_q one edge later, so DNUP is already stable when STEP is high.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            dnup_q  <= 1'b0;
            fire_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dnup_q  <= dnup_d;
            fire_q  <= fire_d;
            step_q  <= fire_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`endif

    assign DNUP = dnup_q;
    assign STEP = step_q;

endmodule

// File: tb/tb_updown_button_ctrl.sv
module tb_updown_button_ctrl;

    logic CLK = 1'b0;
    logic ResetN;
    logic BTN_UP;
    logic BTN_DN;
    logic DNUP;
    logic STEP;

    always #5 CLK = ~CLK;

    updown_button_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W(8),
        .HOLD_CYCLES(64),
        .REPEAT_CYCLES(16)
    ) dut (
        .CLK(CLK),
        .ResetN(ResetN),
        .BTN_UP(BTN_UP),
        .BTN_DN(BTN_DN),
        .DNUP(DNUP),
        .STEP(STEP)
    );

    // Latency from the first sampling edge to STEP high, expressed as the
    // cycle-counter value seen on the falling edge where STEP is high.
    // Inputs change when cyc == c, so the first sampling edge is c+1 and
    // STEP rises on edge c+1+19.
    localparam int LAT = 20;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int   cyc;
        logic dnup;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_step(input int at, input logic d);
        exp_t e;
        e.cyc  = at;
        e.dnup = d;
        sb.push_back(e);
    endtask

    // Monitor: checks every STEP against the scoreboard, plus the DNUP and
    // STEP timing rules.
    logic prev_step = 1'b0;
    logic prev_dnup = 1'b0;

    always @(negedge CLK) begin
        if (STEP === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_step_cyc", cyc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_cyc", cyc, e.cyc);
                check("step_dnup", DNUP, e.dnup);
                check("dnup_before_step", prev_dnup, e.dnup);
            end
            check("step_back_to_back", prev_step, 0);
        end
        if (prev_step === 1'b1) check("dnup_stable_after_step", DNUP, prev_dnup);
        prev_step <= STEP;
        prev_dnup <= DNUP;
    end

    initial begin
        int c0;

        ResetN = 1'b0;
        BTN_UP = 1'b0;
        BTN_DN = 1'b0;
        #1;
        check("reset_step", STEP, 0);
        check("reset_dnup", DNUP, 0);
        wait_cycles(3);
        ResetN = 1'b1;
        wait_cycles(5);

        // 1: clean UP press, one STEP, nothing on release
        BTN_UP = 1'b1;
        expect_step(cyc + LAT, 1'b0);
        wait_cycles(60);
        check("t1_dnup", DNUP, 0);
        BTN_UP = 1'b0;
        wait_cycles(30);
        check("t1_sb_empty", sb.size(), 0);

        // 2: bouncy DN, then stable, gives one STEP; a short UP glitch gives none
        for (int ph = 0; ph < 8; ph++) begin
            BTN_DN = (ph % 2 == 0);
            wait_cycles(3);
        end
        BTN_DN = 1'b1;
        expect_step(cyc + LAT, 1'b1);
        wait_cycles(40);
        check("t2_dnup", DNUP, 1);
        BTN_DN = 1'b0;
        wait_cycles(30);
        BTN_UP = 1'b1;
        wait_cycles(5);
        BTN_UP = 1'b0;
        wait_cycles(40);
        check("t2_glitch_dnup", DNUP, 1);
        check("t2_sb_empty", sb.size(), 0);

        // 3: simultaneous press locks out; a later UP press works
        BTN_UP = 1'b1;
        BTN_DN = 1'b1;
        wait_cycles(40);
        check("t3_lock_dnup", DNUP, 1);
        BTN_UP = 1'b0;
        BTN_DN = 1'b0;
        wait_cycles(30);
        BTN_UP = 1'b1;
        expect_step(cyc + LAT, 1'b0);
        wait_cycles(40);
        BTN_UP = 1'b0;
        wait_cycles(30);
        check("t3_sb_empty", sb.size(), 0);

        // 4: second button while held is ignored, not queued
        BTN_UP = 1'b1;
        expect_step(cyc + LAT, 1'b0);
        wait_cycles(40);
        BTN_DN = 1'b1;
        wait_cycles(40);
        BTN_DN = 1'b0;
        wait_cycles(40);
        check("t4_held_dnup", DNUP, 0);
        BTN_UP = 1'b0;
        wait_cycles(30);
        BTN_DN = 1'b1;
        expect_step(cyc + LAT, 1'b1);
        wait_cycles(40);
        BTN_DN = 1'b0;
        wait_cycles(30);
        check("t4_sb_empty", sb.size(), 0);

        // 5: async reset mid-debounce clears DNUP at once; held UP restarts
        BTN_UP = 1'b1;
        wait_cycles(10);
        #2;
        ResetN = 1'b0;
        #1;
        check("t5_async_dnup", DNUP, 0);
        check("t5_async_step", STEP, 0);
        wait_cycles(3);
        ResetN = 1'b1;
        expect_step(cyc + LAT, 1'b0);
        wait_cycles(40);
        BTN_UP = 1'b0;
        wait_cycles(30);
        check("t5_sb_empty", sb.size(), 0);

        // 5b: reset in the very cycle STEP is high clears it without an edge
        BTN_DN = 1'b1;
        c0 = cyc;
        repeat (LAT) @(posedge CLK);
        #1;
        check("t5b_step_high", STEP, 1);
        check("t5b_step_cyc", cyc, c0 + LAT);
        ResetN = 1'b0;
        #1;
        check("t5b_async_step", STEP, 0);
        check("t5b_async_dnup", DNUP, 0);
        BTN_DN = 1'b0;
        wait_cycles(3);
        ResetN = 1'b1;
        wait_cycles(30);

        // 6: long hold, 200 cycles
        BTN_UP = 1'b1;
        c0 = cyc;
        expect_step(c0 + LAT, 1'b0);
`ifdef AUTO_REPEAT_EN
        // Repeats stop once the debounced release reaches the FSM,
        // 19 cycles after the raw release.
        for (int t = LAT + 64; t <= 200 + 19; t += 16) begin
            expect_step(c0 + t, 1'b0);
        end
`endif
        wait_cycles(200);
        BTN_UP = 1'b0;
        wait_cycles(60);
        check("t6_sb_empty", sb.size(), 0);
        check("t6_dnup", DNUP, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
